// File: rtl/hash_out_mem_writer_pkg.sv
// hash_out_mem_writer_pkg
// Items shared by the digest output writer and the message-side loader:
//   - 2-bit state encodings for the IDLE/RUN/FORCE/DONE sequencer
//   - ceil_words(): number of IO words needed to hold a bit length
package hash_out_mem_writer_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FORCE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Round a bit length up to whole words of 2**log2w bits.
   // Carried at 64 bits so the round-up cannot overflow the length width.
   function automatic logic [63:0] ceil_words(input logic [63:0] len,
                                              input int unsigned log2w);
      logic [63:0] round_up;
      round_up = (64'd1 << log2w) - 64'd1;
      return (len + round_up) >> log2w;
   endfunction

endpackage

// File: rtl/hash_out_mem_writer.sv
// hash_out_mem_writer
// Writes the little-endian digest word stream from the SHAKE output port into
// a word-addressed RAM, then stops squeezing via the force-done handshake.
//
// Ports:
//   clk               system clock, rising edge
//   rst               synchronous active-low reset
//   i_start           start pulse, honoured only in IDLE
//   i_output_length   digest length in bits (multiple of 8), taken with i_start
//   i_data_in         digest word, first byte in [7:0]
//   i_data_in_valid   stream word valid
//   o_data_in_ready   stream ready (RUN only)
//   o_addr            RAM write address
//   o_wr_en           RAM write strobe
//   o_data_out        RAM write data
//   o_force_done      stop-squeezing request to the hash core
//   i_force_done_ack  hash core acknowledge
//   o_busy            high from start until done
//   o_done            one-cycle completion pulse
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for i_start
// ST_RUN   | accepting stream beats, one RAM write per beat
// ST_FORCE | all words stored, holding o_force_done until acknowledged
// ST_DONE  | one-cycle o_done pulse, back to IDLE
module hash_out_mem_writer
   import hash_out_mem_writer_pkg::*;
#(
   parameter int IO_WIDTH      = 32,
   parameter int MAX_RAM_DEPTH = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_start,
   input  logic [IO_WIDTH-1:0]              i_output_length,
   input  logic [IO_WIDTH-1:0]              i_data_in,
   input  logic                             i_data_in_valid,
   output logic                             o_data_in_ready,
   output logic [$clog2(MAX_RAM_DEPTH)-1:0] o_addr,
   output logic                             o_wr_en,
   output logic [IO_WIDTH-1:0]              o_data_out,
   output logic                             o_force_done,
   input  logic                             i_force_done_ack,
   output logic                             o_busy,
   output logic                             o_done
);

   localparam int LOG2W = $clog2(IO_WIDTH);
   localparam int AW    = $clog2(MAX_RAM_DEPTH);
   // count must reach MAX_RAM_DEPTH itself, so one more bit than the address
   // when the depth is a power of two
   localparam int CW    = $clog2(MAX_RAM_DEPTH + 1);

   logic [1:0]          state;
   logic [CW-1:0]       words;
   logic [CW-1:0]       count;
   logic [LOG2W-1:0]    rem;
   logic                mask_en;

   logic [63:0]         start_words_full;
   logic                start_sat;
   logic [CW-1:0]       start_words;
   logic [LOG2W-1:0]    start_rem;
   logic                beat;
   logic                last_beat;
   logic [IO_WIDTH-1:0] beat_data;

   // Ones in bits [r-1:0]; only used when r != 0.
   function automatic logic [IO_WIDTH-1:0] tail_mask(input logic [LOG2W-1:0] r);
      logic [IO_WIDTH-1:0] ones;
      ones = '1;
      return ones >> (IO_WIDTH - int'(r));
   endfunction

   always_comb begin
      start_words_full = ceil_words(64'(i_output_length), LOG2W);
      start_sat        = start_words_full > 64'(MAX_RAM_DEPTH);
      start_words      = start_sat ? CW'(MAX_RAM_DEPTH) : start_words_full[CW-1:0];
      start_rem        = i_output_length[LOG2W-1:0];
   end

   assign o_data_in_ready = (state == ST_RUN);
   assign o_force_done    = (state == ST_FORCE);
   assign o_done          = (state == ST_DONE);
   assign o_busy          = (state != ST_IDLE);

   assign beat      = i_data_in_valid && o_data_in_ready;
   assign last_beat = beat && (count == words - CW'(1));
   assign beat_data = (last_beat && mask_en) ? (i_data_in & tail_mask(rem)) : i_data_in;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         words      <= '0;
         count      <= '0;
         rem        <= '0;
         mask_en    <= 1'b0;
         o_addr     <= '0;
         o_wr_en    <= 1'b0;
         o_data_out <= '0;
      end else begin
         o_wr_en <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  words   <= start_words;
                  rem     <= start_rem;
                  // a saturated length is cut at a word boundary: no tail
                  mask_en <= (start_rem != '0) && !start_sat;
                  count   <= '0;
                  state   <= (start_words == '0) ? ST_FORCE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (beat) begin
                  o_wr_en    <= 1'b1;
                  o_addr     <= count[AW-1:0];
                  o_data_out <= beat_data;
                  count      <= count + CW'(1);
                  if (last_beat)
                     state <= ST_FORCE;
               end
            end
            ST_FORCE: begin
               if (i_force_done_ack)
                  state <= ST_DONE;
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hash_out_mem_writer.sv
module tb_hash_out_mem_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic [31:0] i_output_length;
   logic [31:0] i_data_in;
   logic        i_data_in_valid;
   logic        o_data_in_ready;
   logic [3:0]  o_addr;
   logic        o_wr_en;
   logic [31:0] o_data_out;
   logic        o_force_done;
   logic        i_force_done_ack;
   logic        o_busy;
   logic        o_done;

   hash_out_mem_writer #(.IO_WIDTH(32), .MAX_RAM_DEPTH(16)) dut (
      .clk              (clk),
      .rst              (rst),
      .i_start          (i_start),
      .i_output_length  (i_output_length),
      .i_data_in        (i_data_in),
      .i_data_in_valid  (i_data_in_valid),
      .o_data_in_ready  (o_data_in_ready),
      .o_addr           (o_addr),
      .o_wr_en          (o_wr_en),
      .o_data_out       (o_data_out),
      .o_force_done     (o_force_done),
      .i_force_done_ack (i_force_done_ack),
      .o_busy           (o_busy),
      .o_done           (o_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] len;
      int          exp_writes;
      logic [31:0] exp_last;
      int          ack_delay;   // 0: ack held high for the whole transaction
      bit          gappy;
      int          poke;        // beat index at which to pulse i_start, -1 none
   } vec_t;

   int checks = 0;
   int errors = 0;

   logic [31:0] tx_data [16];
   logic [3:0]  wr_addr [$];
   logic [31:0] wr_data [$];
   int          wr_cyc  [$];
   int          acc_cyc [$];
   int          force_cycles;
   int          first_force;
   int          done_cnt;
   int          done_cyc;
   bit          timed_out;
   logic        busy_after;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fill_pattern();
      for (int k = 0; k < 16; k++) tx_data[k] = {4{8'hA0 + 8'(k)}};
   endtask

   // Runs one transaction in lockstep: sample at negedge, drive 1 after posedge.
   // Start cycle is cycle 1.
   task automatic run_txn(input logic [31:0] len, input int ack_delay,
                          input bit gappy, input int poke);
      int  cyc;
      int  beat;
      int  fseen;
      bit  acc;
      bit  seen_done;
      wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); acc_cyc.delete();
      force_cycles = 0; first_force = -1; done_cnt = 0; done_cyc = -1;
      timed_out = 1'b1;
      cyc = 0; beat = 0; fseen = 0; seen_done = 1'b0;
      @(posedge clk); #1;
      i_output_length  = len;
      i_start          = 1'b1;
      i_data_in        = tx_data[0];
      i_data_in_valid  = 1'b1;
      i_force_done_ack = (ack_delay == 0);
      for (int it = 0; it < 200; it++) begin
         @(negedge clk);
         cyc++;
         if (o_wr_en) begin
            wr_addr.push_back(o_addr);
            wr_data.push_back(o_data_out);
            wr_cyc.push_back(cyc);
         end
         if (o_force_done) begin
            force_cycles++;
            if (first_force < 0) first_force = cyc;
         end
         if (o_done) begin
            done_cnt++;
            done_cyc  = cyc;
            seen_done = 1'b1;
         end
         acc = i_data_in_valid && o_data_in_ready;
         if (acc) acc_cyc.push_back(cyc);
         @(posedge clk); #1;
         if (acc) beat++;
         i_start         = (poke >= 0) && (beat == poke) && acc;
         i_data_in       = (beat < 16) ? tx_data[beat] : 32'hDEAD_BEEF;
         i_data_in_valid = gappy ? ~i_data_in_valid : 1'b1;
         if (o_force_done) fseen++;
         i_force_done_ack = (ack_delay == 0) || ((ack_delay > 0) && (fseen >= ack_delay));
         if (seen_done) begin
            timed_out = 1'b0;
            break;
         end
      end
      busy_after = o_busy;
      i_start = 1'b0; i_data_in_valid = 1'b0; i_force_done_ack = 1'b0;
      // a few idle cycles: nothing may be written after done
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (o_wr_en) wr_addr.push_back(o_addr);
      end
   endtask

   vec_t vecs [13];

   initial begin
      vecs[0]  = '{len: 256,  exp_writes: 8,  exp_last: 32'hA7A7A7A7, ack_delay: 2, gappy: 0, poke: -1};
      vecs[1]  = '{len: 256,  exp_writes: 8,  exp_last: 32'hA7A7A7A7, ack_delay: 1, gappy: 0, poke: -1};
      vecs[2]  = '{len: 128,  exp_writes: 4,  exp_last: 32'hA3A3A3A3, ack_delay: 1, gappy: 1, poke: -1};
      vecs[3]  = '{len: 40,   exp_writes: 2,  exp_last: 32'h000000A1, ack_delay: 1, gappy: 0, poke: -1};
      vecs[4]  = '{len: 24,   exp_writes: 1,  exp_last: 32'h00A0A0A0, ack_delay: 1, gappy: 0, poke: -1};
      vecs[5]  = '{len: 32,   exp_writes: 1,  exp_last: 32'hA0A0A0A0, ack_delay: 1, gappy: 0, poke: -1};
      vecs[6]  = '{len: 48,   exp_writes: 2,  exp_last: 32'h0000A1A1, ack_delay: 3, gappy: 1, poke: -1};
      vecs[7]  = '{len: 0,    exp_writes: 0,  exp_last: 32'h0,        ack_delay: 1, gappy: 0, poke: -1};
      vecs[8]  = '{len: 0,    exp_writes: 0,  exp_last: 32'h0,        ack_delay: 3, gappy: 0, poke: -1};
      vecs[9]  = '{len: 1024, exp_writes: 16, exp_last: 32'hAFAFAFAF, ack_delay: 1, gappy: 0, poke: 5};
      vecs[10] = '{len: 520,  exp_writes: 16, exp_last: 32'hAFAFAFAF, ack_delay: 1, gappy: 0, poke: -1};
      vecs[11] = '{len: 496,  exp_writes: 16, exp_last: 32'h0000AFAF, ack_delay: 0, gappy: 0, poke: -1};
      vecs[12] = '{len: 8,    exp_writes: 1,  exp_last: 32'h000000A0, ack_delay: 0, gappy: 1, poke: -1};

      rst = 1'b0; i_start = 1'b0; i_output_length = '0; i_data_in = '0;
      i_data_in_valid = 1'b0; i_force_done_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_wr_en", {31'b0, o_wr_en}, 0);
      chk("reset_addr", {28'b0, o_addr}, 0);
      chk("reset_data", o_data_out, 0);
      chk("reset_force", {31'b0, o_force_done}, 0);
      chk("reset_busy_done_ready", {29'b0, o_busy, o_done, o_data_in_ready}, 0);
      rst = 1'b1;
      fill_pattern();

      for (int v = 0; v < 13; v++) begin
         int exp_force;
         run_txn(vecs[v].len, vecs[v].ack_delay, vecs[v].gappy, vecs[v].poke);
         exp_force = (vecs[v].ack_delay == 0) ? 1 : vecs[v].ack_delay;
         chk($sformatf("v%0d_timeout", v), {31'b0, timed_out}, 0);
         chk($sformatf("v%0d_writes", v), wr_addr.size(), vecs[v].exp_writes);
         for (int k = 0; k < wr_data.size() && k < vecs[v].exp_writes; k++) begin
            chk($sformatf("v%0d_addr%0d", v, k), {28'b0, wr_addr[k]}, k);
            chk($sformatf("v%0d_data%0d", v, k), wr_data[k],
                (k == vecs[v].exp_writes - 1) ? vecs[v].exp_last : tx_data[k]);
            if (k < acc_cyc.size())
               chk($sformatf("v%0d_wrlat%0d", v, k), wr_cyc[k], acc_cyc[k] + 1);
         end
         if (vecs[v].exp_writes > 0 && wr_cyc.size() > 0)
            chk($sformatf("v%0d_last_wr_vs_force", v), wr_cyc[wr_cyc.size()-1], first_force);
         else
            chk($sformatf("v%0d_force_rise", v), first_force, 2);
         chk($sformatf("v%0d_force_cycles", v), force_cycles, exp_force);
         chk($sformatf("v%0d_done_cnt", v), done_cnt, 1);
         chk($sformatf("v%0d_busy_after", v), {31'b0, busy_after}, 0);
         if (vecs[v].ack_delay == 1 && !vecs[v].gappy)
            chk($sformatf("v%0d_latency", v), done_cyc - 1, vecs[v].exp_writes + 2);
      end

      // len=40 with explicit byte-ordered words
      tx_data[0] = 32'hDDCCBBAA;
      tx_data[1] = 32'h44332211;
      run_txn(32'd40, 1, 1'b0, -1);
      chk("len40_writes", wr_addr.size(), 2);
      if (wr_data.size() >= 2) begin
         chk("len40_addr0", wr_data[0], 32'hDDCCBBAA);
         chk("len40_addr1", wr_data[1], 32'h00000011);
      end
      fill_pattern();

      // reset during RUN after 3 accepted beats
      begin
         int  beats = 0;
         int  late_wr = 0;
         bit  acc;
         @(posedge clk); #1;
         i_output_length = 32'd256; i_start = 1'b1;
         i_data_in = tx_data[0]; i_data_in_valid = 1'b1;
         for (int it = 0; it < 50 && beats < 3; it++) begin
            @(negedge clk);
            acc = i_data_in_valid && o_data_in_ready;
            @(posedge clk); #1;
            i_start = 1'b0;
            if (acc) beats++;
            i_data_in = tx_data[beats];
         end
         chk("rst_seq_beats", beats, 3);
         rst = 1'b0;
         @(posedge clk); #1;
         chk("rst_mid_wr_en", {31'b0, o_wr_en}, 0);
         chk("rst_mid_addr_data", {o_addr, o_data_out[27:0]}, 0);
         chk("rst_mid_force_busy_done_ready",
             {28'b0, o_force_done, o_busy, o_done, o_data_in_ready}, 0);
         rst = 1'b1;
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (o_wr_en) late_wr++;
         end
         chk("rst_no_late_writes", late_wr, 0);
         i_data_in_valid = 1'b0;
      end
      run_txn(32'd64, 1, 1'b0, -1);
      chk("post_rst_writes", wr_addr.size(), 2);
      if (wr_addr.size() >= 1) begin
         chk("post_rst_addr0", {28'b0, wr_addr[0]}, 0);
         chk("post_rst_data0", wr_data[0], 32'hA0A0A0A0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
